// File: rtl/mul_issue_pkg.sv
// rtl/mul_issue_pkg.sv - shared widths, limits and state encoding for the multiply issue stage
package mul_issue_pkg;
    localparam int DATA_W      = 32;
    localparam int TAG_W       = 5;
    localparam int MUL_LATENCY = 33;
    localparam int WDOG_LIMIT  = 40;

    localparam logic [1:0] ST_FLUSH = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_RSP   = 2'd3;
endpackage

// File: rtl/mul_issue_if.sv
// rtl/mul_issue_if.sv - request/response handshake bundle between issuer and mul_issue
interface mul_issue_if;
    import mul_issue_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_signed;
    logic [DATA_W-1:0] req_x;
    logic [DATA_W-1:0] req_y;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_lo;
    logic [DATA_W-1:0] rsp_hi;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (
        output req_valid, req_signed, req_x, req_y, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_tag
    );
    modport slave (
        input  req_valid, req_signed, req_x, req_y, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_tag
    );
endinterface

// File: rtl/mul_issue.sv
// rtl/mul_issue.sv - issues one multiply to the sibling iterative multiplier and returns the tagged product
module mul_issue
    import mul_issue_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    mul_issue_if.slave          bus,
    output logic                mul_run,
    output logic                mul_u,
    output logic [DATA_W-1:0]   mul_x,
    output logic [DATA_W-1:0]   mul_y,
    input  logic                mul_stall,
    input  logic [2*DATA_W-1:0] mul_z,
    output logic                mul_err
);
    logic [1:0]        state;
    logic              op_u;
    logic [DATA_W-1:0] op_x;
    logic [DATA_W-1:0] op_y;
    logic [TAG_W-1:0]  op_tag;
    logic [5:0]        wdog;
    logic [5:0]        wdog_inc;
    logic [DATA_W-1:0] rsp_lo;
    logic [DATA_W-1:0] rsp_hi;
    logic [TAG_W-1:0]  rsp_tag;
    logic              err;
    logic              req_fire;

    // Accepting in RSP while the response drains gives back-to-back issue with one idle mul_run cycle.
    assign bus.req_ready = (state == ST_IDLE) || ((state == ST_RSP) && bus.rsp_ready);
    assign bus.rsp_valid = (state == ST_RSP);
    assign bus.rsp_lo    = rsp_lo;
    assign bus.rsp_hi    = rsp_hi;
    assign bus.rsp_tag   = rsp_tag;

    assign mul_run  = (state == ST_RUN);
    assign mul_u    = op_u;
    assign mul_x    = op_x;
    assign mul_y    = op_y;
    assign mul_err  = err;
    assign req_fire = bus.req_valid && bus.req_ready;
    assign wdog_inc = wdog + 6'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FLUSH;
            op_u    <= 1'b0;
            op_x    <= '0;
            op_y    <= '0;
            op_tag  <= '0;
            wdog    <= '0;
            rsp_lo  <= '0;
            rsp_hi  <= '0;
            rsp_tag <= '0;
            err     <= 1'b0;
        end else if (ce) begin
            if (req_fire) begin
                op_u   <= ~bus.req_signed;
                op_x   <= bus.req_x;
                op_y   <= bus.req_y;
                op_tag <= bus.req_tag;
                wdog   <= '0;
            end
            case (state)
                ST_FLUSH: state <= ST_IDLE;
                ST_IDLE: begin
                    if (bus.req_valid) state <= ST_RUN;
                end
                ST_RUN: begin
                    wdog <= wdog_inc;
                    if (!mul_stall) begin
                        rsp_lo  <= mul_z[DATA_W-1:0];
                        rsp_hi  <= mul_z[2*DATA_W-1:DATA_W];
                        rsp_tag <= op_tag;
                        state   <= ST_RSP;
                    end else if (wdog_inc == 6'(WDOG_LIMIT)) begin
                        // A hung multiplier is abandoned with a zero result so the pipeline keeps draining.
                        err     <= 1'b1;
                        rsp_lo  <= '0;
                        rsp_hi  <= '0;
                        rsp_tag <= op_tag;
                        state   <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (bus.rsp_ready) state <= bus.req_valid ? ST_RUN : ST_IDLE;
                end
                default: state <= ST_FLUSH;
            endcase
        end
    end
endmodule
